// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: state encoding and control-word layout.
package seq_pkg;

  localparam int CTRL_W    = 13;
  localparam int CTRL_BR   = 0;
  localparam int CTRL_RW   = 1;
  localparam int CTRL_MEM  = 2;
  localparam int CTRL_MWR  = 3;
  localparam int CTRL_HALT = 12;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

endpackage

// File: rtl/seq_timeout.sv
// Clearable memory-wait counter; expired flags the last permitted wait cycle.
module seq_timeout #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] LIMIT = TW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // One more unacknowledged cycle from here would reach MEM_TIMEOUT.
  always_comb begin
    expired = (MEM_TIMEOUT != 0) && (cnt_q == LIMIT);
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/write-back sequencer with halt and memory-timeout fault.
// Optional retired-instruction counter enabled by defining SEQ_PERF_CNT_EN.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CTRL_W-1:0] ctrl,
  input  logic              cond,
  output logic              imem_req,
  input  logic              imem_ack,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ack,
  output logic              ir_load,
  output logic              pc_inc,
  output logic              pc_load,
  output logic              reg_we,
  output logic              busy,
  output logic              halted,
  output logic              err,
  output logic [2:0]        state
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  retired
`endif
);

  state_t state_q;
  state_t state_d;
  logic   retire;
  logic   ir_pulse;
  logic   take_branch;
  logic   wait_inc;
  logic   timeout_clr;
  logic   expired;
  logic   unused_ctrl;

  assign unused_ctrl = ^ctrl[11:4];

  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    ir_pulse = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_pulse = 1'b1;
          state_d  = S_DECODE;
        end else if (expired) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        state_d = ctrl[CTRL_HALT] ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (ctrl[CTRL_MEM]) begin
          state_d = S_MEM;
        end else if (ctrl[CTRL_RW]) begin
          state_d = S_WB;
        end else begin
          retire = 1'b1;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (ctrl[CTRL_RW]) state_d = S_WB;
          else retire = 1'b1;
        end else if (expired) begin
          state_d = S_FAULT;
        end
      end
      S_WB: begin
        retire = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
    if (retire) state_d = S_FETCH;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Any state change clears the wait counter, which covers entry to FETCH and MEM.
  always_comb begin
    wait_inc    = ((state_q == S_FETCH) && !imem_ack) ||
                  ((state_q == S_MEM) && !dmem_ack);
    timeout_clr = (state_d != state_q);
  end

  seq_timeout #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (timeout_clr),
    .inc    (wait_inc),
    .expired(expired)
  );

  // Pulses are suppressed while reset is asserted so an aborted instruction has no side effects.
  always_comb begin
    take_branch = ctrl[CTRL_BR] && cond;
    ir_load     = rst_n && ir_pulse;
    pc_load     = rst_n && retire && take_branch;
    pc_inc      = rst_n && retire && !take_branch;
  end

  always_comb begin
    state    = state_q;
    imem_req = (state_q == S_FETCH);
    dmem_req = (state_q == S_MEM);
    dmem_we  = (state_q == S_MEM) && ctrl[CTRL_MWR];
    reg_we   = (state_q == S_WB);
    busy     = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_FAULT);
    halted   = (state_q == S_HALT);
    err      = (state_q == S_FAULT);
  end

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] retired_q;
  logic [CNT_W-1:0] retired_d;

  always_comb begin
    retired_d = retired_q;
    if (retire) retired_d = retired_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed scoreboard bench for instr_sequencer (MEM_TIMEOUT=4); checks retired when SEQ_PERF_CNT_EN is defined.
module tb_instr_sequencer;

  localparam int CNT_W = 32;
  localparam int W     = 13 + CNT_W;

  localparam logic [2:0] IDL = 3'd0;
  localparam logic [2:0] FET = 3'd1;
  localparam logic [2:0] DEC = 3'd2;
  localparam logic [2:0] EXE = 3'd3;
  localparam logic [2:0] MEM = 3'd4;
  localparam logic [2:0] WBK = 3'd5;
  localparam logic [2:0] HLT = 3'd6;
  localparam logic [2:0] FLT = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [12:0] ctrl;
  logic        cond;
  logic        imem_ack;
  logic        dmem_ack;
  logic        imem_req, dmem_req, dmem_we, ir_load, pc_inc, pc_load, reg_we;
  logic        busy, halted, err;
  logic [2:0]  state;
`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] retired;
`endif

  logic [W-1:0]     exp_q[$];
  string            name_q[$];
  logic [CNT_W-1:0] exp_ret;
  int               n_vec = 0;
  int               n_err = 0;

  // clock / reset
  always #5 clk = ~clk;

  instr_sequencer #(
    .MEM_TIMEOUT(4),
    .CNT_W      (CNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .ctrl    (ctrl),
    .cond    (cond),
    .imem_req(imem_req),
    .imem_ack(imem_ack),
    .dmem_req(dmem_req),
    .dmem_we (dmem_we),
    .dmem_ack(dmem_ack),
    .ir_load (ir_load),
    .pc_inc  (pc_inc),
    .pc_load (pc_load),
    .reg_we  (reg_we),
    .busy    (busy),
    .halted  (halted),
    .err     (err),
    .state   (state)
`ifdef SEQ_PERF_CNT_EN
    ,
    .retired (retired)
`endif
  );

  function automatic logic [W-1:0] exp_vec(input logic [2:0] st, input logic eir, einc, eld,
                                           input logic [CNT_W-1:0] ret);
    logic bsy;
    bsy = (st != IDL) && (st != HLT) && (st != FLT);
    exp_vec = {st, st == FET, st == MEM, (st == MEM) && ctrl[3], eir, einc, eld,
               st == WBK, bsy, st == HLT, st == FLT, ret};
  endfunction

  // driver: apply one cycle of inputs and queue the expected outputs for that cycle
  task automatic cyc(input logic s, ia, da, rn, input logic [2:0] est,
                     input logic eir, einc, eld, input string nm);
    start    = s;
    imem_ack = ia;
    dmem_ack = da;
    rst_n    = rn;
`ifdef SEQ_PERF_CNT_EN
    exp_q.push_back(exp_vec(est, eir, einc, eld, exp_ret));
`else
    exp_q.push_back(exp_vec(est, eir, einc, eld, '0));
`endif
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    if (!rn) exp_ret = '0;
    else if (einc || eld) exp_ret = exp_ret + 1'b1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      string        nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
`ifdef SEQ_PERF_CNT_EN
      a = {state, imem_req, dmem_req, dmem_we, ir_load, pc_inc, pc_load, reg_we,
           busy, halted, err, retired};
`else
      a = {state, imem_req, dmem_req, dmem_we, ir_load, pc_inc, pc_load, reg_we,
           busy, halted, err, {CNT_W{1'b0}}};
`endif
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL %s: got st=%0d flags=%b ret=%0d, expected st=%0d flags=%b ret=%0d",
                 nm, a[W-1 -: 3], a[W-4 -: 10], a[CNT_W-1:0],
                 e[W-1 -: 3], e[W-4 -: 10], e[CNT_W-1:0]);
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    ctrl     = '0;
    cond     = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    exp_ret  = '0;
    repeat (2) @(posedge clk);
    #1;

    cyc(0, 0, 0, 1, IDL, 0, 0, 0, "reset_idle");

    // ALU with register write
    ctrl = 13'd2;
    cyc(1, 0, 0, 1, IDL, 0, 0, 0, "start");
    cyc(0, 1, 0, 1, FET, 1, 0, 0, "alu_fetch");
    cyc(0, 0, 0, 1, DEC, 0, 0, 0, "alu_decode");
    cyc(0, 0, 0, 1, EXE, 0, 0, 0, "alu_exec");
    cyc(0, 0, 0, 1, WBK, 0, 1, 0, "alu_wb");

    // load with three wait cycles
    ctrl = 13'd6;
    cyc(0, 1, 0, 1, FET, 1, 0, 0, "load_fetch");
    cyc(0, 0, 0, 1, DEC, 0, 0, 0, "load_decode");
    cyc(0, 0, 0, 1, EXE, 0, 0, 0, "load_exec");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, MEM, 0, 0, 0, "load_wait");
    cyc(0, 0, 1, 1, MEM, 0, 0, 0, "load_ack");
    cyc(0, 0, 0, 1, WBK, 0, 1, 0, "load_wb");

    // store, zero wait
    ctrl = 13'd12;
    cyc(0, 1, 0, 1, FET, 1, 0, 0, "store_fetch");
    cyc(0, 0, 0, 1, DEC, 0, 0, 0, "store_decode");
    cyc(0, 0, 0, 1, EXE, 0, 0, 0, "store_exec");
    cyc(0, 0, 1, 1, MEM, 0, 1, 0, "store_ack");

    // branch taken, stray acks in DECODE ignored
    ctrl = 13'd1;
    cond = 1'b1;
    cyc(0, 1, 0, 1, FET, 1, 0, 0, "br_fetch");
    cyc(0, 1, 1, 1, DEC, 0, 0, 0, "br_decode_stray_ack");
    cyc(0, 0, 0, 1, EXE, 0, 0, 1, "br_taken");
    cond = 1'b0;
    cyc(0, 1, 0, 1, FET, 1, 0, 0, "br2_fetch");
    cyc(0, 0, 0, 1, DEC, 0, 0, 0, "br2_decode");
    cyc(0, 0, 0, 1, EXE, 0, 1, 0, "br_not_taken");

    // fetch ack arriving on the last permitted cycle
    ctrl = 13'd0;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, FET, 0, 0, 0, "fetch_wait");
    cyc(0, 1, 0, 1, FET, 1, 0, 0, "fetch_ack_at_limit");
    cyc(0, 0, 0, 1, DEC, 0, 0, 0, "nop_decode");
    cyc(0, 0, 0, 1, EXE, 0, 1, 0, "nop_exec");

    // fetch timeout -> sticky fault
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, FET, 0, 0, 0, "fetch_timeout_wait");
    cyc(1, 1, 1, 1, FLT, 0, 0, 0, "fault");
    cyc(1, 1, 1, 1, FLT, 0, 0, 0, "fault_sticky");
    cyc(0, 0, 0, 0, FLT, 0, 0, 0, "reset_in_fault");

    // reset while a memory ack is present: no pulse, back to IDLE
    cyc(1, 0, 0, 1, IDL, 0, 0, 0, "idle_after_fault_reset");
    ctrl = 13'd4;
    cyc(0, 1, 0, 1, FET, 1, 0, 0, "mem_fetch");
    cyc(0, 0, 0, 1, DEC, 0, 0, 0, "mem_decode");
    cyc(0, 0, 0, 1, EXE, 0, 0, 0, "mem_exec");
    cyc(0, 0, 1, 0, MEM, 0, 0, 0, "reset_in_mem");
    cyc(1, 0, 0, 1, IDL, 0, 0, 0, "idle_after_mem_reset");
    cyc(0, 0, 0, 1, FET, 0, 0, 0, "restart_fetch");

    // halt: sticky, ignores start and acks
    ctrl = 13'd4096;
    cyc(0, 1, 0, 1, FET, 1, 0, 0, "halt_fetch");
    cyc(0, 0, 0, 1, DEC, 0, 0, 0, "halt_decode");
    for (int i = 0; i < 20; i++) cyc(i[0], 1, 1, 1, HLT, 0, 0, 0, "halt_hold");

    @(negedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
